rf_cmd_controller: RTL and testbench
====================================

Name: rf_cmd_controller

Overview:
Command sequencer between the UART receive/transmit byte streams and the register file. Parses framed byte commands from the RX path and issues register-file write and read strobes. Returns read data to the TX path over a valid/ready handshake. Flags malformed commands and bytes dropped while busy.

Parameters:
WIDTH, 8, data byte and register width (command, address and data bytes are all WIDTH bits)
DEPTH_BITS, 4, register file address width
WR_OPCODE, 8'hAA, opcode of the write command
RD_OPCODE, 8'hBB, opcode of the read command
RD_TIMEOUT, 4, cycles to wait for RF_RdData_Valid before aborting

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous active-low reset
RX_P_Data  input  WIDTH  received byte
RX_D_VLD  input  1  one-cycle pulse, RX_P_Data valid
RF_Address  output  DEPTH_BITS  register file address
RF_WrData  output  WIDTH  register file write data
RF_WrEn  output  1  register file write strobe, one-cycle pulse
RF_RdEn  output  1  register file read strobe, one-cycle pulse
RF_RdData  input  WIDTH  register file read data
RF_RdData_Valid  input  1  register file read data valid
TX_P_Data  output  WIDTH  byte to transmit
TX_Valid  output  1  TX_P_Data valid; held until accepted
TX_Ready  input  1  TX path accepts the byte when TX_Valid and TX_Ready are both high on a rising edge
Cmd_Err  output  1  one-cycle pulse on a malformed or aborted command
Rx_Drop  output  1  one-cycle pulse when a received byte is discarded while busy

Behaviour:
- Reset (RST low, asynchronous): state IDLE.
- Reset values: all outputs 0, including RF_Address, RF_WrData, TX_P_Data, internal address and data registers.
- Reset mid-command aborts the command with no RF strobe.
- All outputs are registered. RF_WrEn and RF_RdEn are never high in the same cycle.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE, byte accepted:
  - WR_OPCODE -> WR_ADDR.
  - RD_OPCODE -> RD_ADDR.
  - Any other value: Cmd_Err pulses in the next cycle; stay in IDLE.
- Address byte check (WR_ADDR, RD_ADDR):
  - Bits [WIDTH-1:DEPTH_BITS] must be zero.
  - If not: Cmd_Err pulses, return to IDLE, no strobe.
  - If valid: latch the low DEPTH_BITS into RF_Address. WR_ADDR -> WR_DATA.
- WR_DATA, byte accepted: RF_WrData takes the byte and RF_WrEn is high for exactly one cycle, the cycle after RX_D_VLD is sampled. -> IDLE.
- RD_ADDR, valid address byte: RF_RdEn is high for one cycle, the cycle after RX_D_VLD is sampled. -> RD_WAIT.
- RD_WAIT:
  - On RF_RdData_Valid: capture RF_RdData into TX_P_Data; TX_Valid goes high the next cycle. -> TX_SEND.
  - Timeout: if RF_RdData_Valid has not arrived within RD_TIMEOUT cycles after RF_RdEn, Cmd_Err pulses -> IDLE.
- TX_SEND:
  - TX_Valid and TX_P_Data stay stable until TX_Valid and TX_Ready are both high on an edge.
  - TX_Valid drops in the following cycle. -> IDLE.
  - No timeout on TX_Ready.
- Bytes are accepted only in IDLE, WR_ADDR, WR_DATA and RD_ADDR.
- A byte arriving in RD_WAIT or TX_SEND is discarded and Rx_Drop pulses the next cycle. The current command is not disturbed.
- Back-to-back commands: a byte arriving the cycle after the return to IDLE is accepted. No dead cycle beyond the registered strobe.
- RX_D_VLD while already in WR_DATA or WR_ADDR is always taken as the next field; there is no inter-byte timeout.

Test Plan:
- Write: bytes AA, 03, 5C. -> one RF_WrEn pulse with RF_Address=3, RF_WrData=5C; Cmd_Err never asserts.
- Read: preload reg 3 = 5C, TX_Ready=1; bytes BB, 03. -> one RF_RdEn pulse with address 3; TX_Valid with TX_P_Data=5C for exactly one cycle.
- TX backpressure: read with TX_Ready=0 for 10 cycles, then 1. -> TX_Valid and TX_P_Data=5C stable for all 10 cycles; accepted once; then IDLE.
- Errors:
  - Byte 7E in IDLE -> Cmd_Err pulse, no strobes.
  - Bytes AA, 13 -> Cmd_Err pulse (address out of range), no RF_WrEn.
  - Read with RF_RdData_Valid tied low -> Cmd_Err exactly RD_TIMEOUT cycles after RF_RdEn.
- Drop: during TX_SEND with TX_Ready=0, send byte AA. -> Rx_Drop pulse; pending TX byte is unchanged; a following AA, 01, FF write completes normally.
- Reset mid-command: bytes AA, 02, then RST low, then release, then byte 11. -> no RF_WrEn; 11 is treated as an unknown opcode and Cmd_Err pulses.

Source files
------------

// File: rtl/rf_cmd_controller.sv
// Byte-command sequencer between the UART RX/TX streams and the register file.
// Decodes write/read frames, strobes the register file and returns read data over valid/ready.
module rf_cmd_controller #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEPTH_BITS = 4,
  parameter logic [WIDTH-1:0] WR_OPCODE  = 8'hAA,
  parameter logic [WIDTH-1:0] RD_OPCODE  = 8'hBB,
  parameter int unsigned      RD_TIMEOUT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      RX_P_Data,
  input  logic                  RX_D_VLD,
  output logic [DEPTH_BITS-1:0] RF_Address,
  output logic [WIDTH-1:0]      RF_WrData,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  input  logic [WIDTH-1:0]      RF_RdData,
  input  logic                  RF_RdData_Valid,
  output logic [WIDTH-1:0]      TX_P_Data,
  output logic                  TX_Valid,
  input  logic                  TX_Ready,
  output logic                  Cmd_Err,
  output logic                  Rx_Drop
);

  localparam int unsigned TMR_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_BITS-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wr_data_q, wr_data_d;
  logic [WIDTH-1:0]      tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  rx_drop_q, rx_drop_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  addr_ok;

  // Address bytes must fit in the register file; any high bit set is malformed.
  assign addr_ok = (RX_P_Data[WIDTH-1:DEPTH_BITS] == '0);

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_data_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      cmd_err_q  <= 1'b0;
      rx_drop_q  <= 1'b0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      cmd_err_q  <= cmd_err_d;
      rx_drop_q  <= rx_drop_d;
      tmr_q      <= tmr_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    cmd_err_d  = 1'b0;
    rx_drop_d  = 1'b0;
    tmr_d      = tmr_q;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_Data == WR_OPCODE) begin
            state_d = WR_ADDR;
          end else if (RX_P_Data == RD_OPCODE) begin
            state_d = RD_ADDR;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end

      WR_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            addr_d  = RX_P_Data[DEPTH_BITS-1:0];
            state_d = WR_DATA;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_Data;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
      end

      RD_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            addr_d  = RX_P_Data[DEPTH_BITS-1:0];
            rd_en_d = 1'b1;
            tmr_d   = '0;
            state_d = RD_WAIT;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      // Timer counts cycles since the read strobe; the last window cycle still accepts data.
      RD_WAIT: begin
        rx_drop_d = RX_D_VLD;
        if (RF_RdData_Valid) begin
          tx_data_d  = RF_RdData;
          tx_valid_d = 1'b1;
          state_d    = TX_SEND;
        end else if (tmr_q == TMR_W'(RD_TIMEOUT - 1)) begin
          cmd_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      TX_SEND: begin
        rx_drop_d = RX_D_VLD;
        if (tx_valid_q && TX_Ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign RF_Address = addr_q;
  assign RF_WrData  = wr_data_q;
  assign RF_WrEn    = wr_en_q;
  assign RF_RdEn    = rd_en_q;
  assign TX_P_Data  = tx_data_q;
  assign TX_Valid   = tx_valid_q;
  assign Cmd_Err    = cmd_err_q;
  assign Rx_Drop    = rx_drop_q;

endmodule

// File: tb/tb_rf_cmd_controller.sv
// Directed self-checking bench for rf_cmd_controller with a small register-file model
// and edge monitors that count strobes, errors, drops and TX handshakes.
module tb_rf_cmd_controller;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned DEPTH_BITS = 4;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [WIDTH-1:0]      RX_P_Data;
  logic                  RX_D_VLD;
  logic [DEPTH_BITS-1:0] RF_Address;
  logic [WIDTH-1:0]      RF_WrData;
  logic                  RF_WrEn;
  logic                  RF_RdEn;
  logic [WIDTH-1:0]      RF_RdData;
  logic                  RF_RdData_Valid;
  logic [WIDTH-1:0]      TX_P_Data;
  logic                  TX_Valid;
  logic                  TX_Ready;
  logic                  Cmd_Err;
  logic                  Rx_Drop;

  rf_cmd_controller dut (
    .CLK             (CLK),
    .RST             (RST),
    .RX_P_Data       (RX_P_Data),
    .RX_D_VLD        (RX_D_VLD),
    .RF_Address      (RF_Address),
    .RF_WrData       (RF_WrData),
    .RF_WrEn         (RF_WrEn),
    .RF_RdEn         (RF_RdEn),
    .RF_RdData       (RF_RdData),
    .RF_RdData_Valid (RF_RdData_Valid),
    .TX_P_Data       (TX_P_Data),
    .TX_Valid        (TX_Valid),
    .TX_Ready        (TX_Ready),
    .Cmd_Err         (Cmd_Err),
    .Rx_Drop         (Rx_Drop)
  );

  always #5 CLK = ~CLK;

  // Register file model: one-cycle read latency, read response can be muted.
  logic [WIDTH-1:0] mem [16];
  logic             mute;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      RF_RdData_Valid <= 1'b0;
      RF_RdData       <= '0;
    end else begin
      if (RF_WrEn) mem[RF_Address] <= RF_WrData;
      RF_RdData_Valid <= RF_RdEn && !mute;
      if (RF_RdEn) RF_RdData <= mem[RF_Address];
    end
  end

  // Edge monitors
  int cyc = 0, wr_cnt = 0, rd_cnt = 0, err_cnt = 0, drop_cnt = 0;
  int acc_cnt = 0, txv_cnt = 0, both_cnt = 0, rd_cyc = 0, err_cyc = 0;
  logic [7:0] wr_addr_seen = '0, wr_data_seen = '0, rd_addr_seen = '0, tx_data_seen = '0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RF_WrEn) begin
      wr_cnt       <= wr_cnt + 1;
      wr_addr_seen <= 8'(RF_Address);
      wr_data_seen <= RF_WrData;
    end
    if (RF_RdEn) begin
      rd_cnt       <= rd_cnt + 1;
      rd_addr_seen <= 8'(RF_Address);
      rd_cyc       <= cyc;
    end
    if (RF_WrEn && RF_RdEn) both_cnt <= both_cnt + 1;
    if (Cmd_Err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (Rx_Drop) drop_cnt <= drop_cnt + 1;
    if (TX_Valid) txv_cnt <= txv_cnt + 1;
    if (TX_Valid && TX_Ready) begin
      acc_cnt      <= acc_cnt + 1;
      tx_data_seen <= TX_P_Data;
    end
  end

  int n_checks = 0;
  int n_fails  = 0;
  int b_wr, b_rd, b_err, b_drop, b_acc, b_txv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_wr = wr_cnt; b_rd = rd_cnt; b_err = err_cnt;
    b_drop = drop_cnt; b_acc = acc_cnt; b_txv = txv_cnt;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RX_P_Data = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_txv(input string tag);
    int k;
    k = 0;
    while (!TX_Valid && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check(tag, 32'(TX_Valid), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [6];
    int         stable;

    RST = 1'b0; RX_D_VLD = 1'b0; RX_P_Data = '0; TX_Ready = 1'b1; mute = 1'b0;
    wait_cyc(3);
    check("rst_strobes", 32'({RF_WrEn, RF_RdEn, TX_Valid, Cmd_Err, Rx_Drop}), 0);
    check("rst_addr", 32'(RF_Address), 0);
    check("rst_wrdata", 32'(RF_WrData), 0);
    check("rst_txdata", 32'(TX_P_Data), 0);
    RST = 1'b1;
    wait_cyc(2);

    // Write AA 03 5C
    snap();
    send(8'hAA); send(8'h03); send(8'h5C);
    wait_cyc(3);
    check("wr_pulses", 32'(wr_cnt - b_wr), 1);
    check("wr_addr", 32'(wr_addr_seen), 32'h3);
    check("wr_data", 32'(wr_data_seen), 32'h5C);
    check("wr_no_err", 32'(err_cnt - b_err), 0);
    check("wr_no_rd", 32'(rd_cnt - b_rd), 0);

    // Read BB 03 with TX_Ready high
    snap();
    TX_Ready = 1'b1;
    send(8'hBB); send(8'h03);
    wait_cyc(8);
    check("rd_pulses", 32'(rd_cnt - b_rd), 1);
    check("rd_addr", 32'(rd_addr_seen), 32'h3);
    check("rd_tx_acc", 32'(acc_cnt - b_acc), 1);
    check("rd_tx_data", 32'(tx_data_seen), 32'h5C);
    check("rd_txv_cycles", 32'(txv_cnt - b_txv), 1);
    check("rd_no_err", 32'(err_cnt - b_err), 0);

    // Read with 10 cycles of backpressure
    snap();
    TX_Ready = 1'b0;
    send(8'hBB); send(8'h03);
    wait_txv("bp_txv_rise");
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (TX_Valid && TX_P_Data == 8'h5C) stable++;
      @(negedge CLK);
    end
    check("bp_stable", 32'(stable), 10);
    check("bp_no_acc_yet", 32'(acc_cnt - b_acc), 0);
    TX_Ready = 1'b1;
    wait_cyc(3);
    check("bp_acc_once", 32'(acc_cnt - b_acc), 1);
    check("bp_txv_low", 32'(TX_Valid), 0);

    // Byte dropped while TX pending, then a normal write
    snap();
    TX_Ready = 1'b0;
    send(8'hBB); send(8'h03);
    wait_txv("drop_txv_rise");
    send(8'hAA);
    wait_cyc(1);
    check("drop_pulse", 32'(drop_cnt - b_drop), 1);
    check("drop_tx_data", 32'(TX_P_Data), 32'h5C);
    check("drop_txv_held", 32'(TX_Valid), 1);
    TX_Ready = 1'b1;
    wait_cyc(3);
    check("drop_acc", 32'(acc_cnt - b_acc), 1);
    snap();
    send(8'hAA); send(8'h01); send(8'hFF);
    wait_cyc(3);
    check("post_drop_wr", 32'(wr_cnt - b_wr), 1);
    check("post_drop_addr", 32'(wr_addr_seen), 32'h1);
    check("post_drop_data", 32'(wr_data_seen), 32'hFF);
    check("post_drop_err", 32'(err_cnt - b_err), 0);

    // Two writes fully back to back
    snap();
    seq[0] = 8'hAA; seq[1] = 8'h04; seq[2] = 8'h33;
    seq[3] = 8'hAA; seq[4] = 8'h05; seq[5] = 8'h44;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      RX_P_Data = seq[i];
      RX_D_VLD  = 1'b1;
    end
    @(negedge CLK);
    RX_D_VLD = 1'b0;
    wait_cyc(3);
    check("b2b_wr", 32'(wr_cnt - b_wr), 2);
    check("b2b_addr", 32'(wr_addr_seen), 32'h5);
    check("b2b_data", 32'(wr_data_seen), 32'h44);
    check("b2b_err", 32'(err_cnt - b_err), 0);

    // Unknown opcode
    snap();
    send(8'h7E);
    wait_cyc(2);
    check("badop_err", 32'(err_cnt - b_err), 1);
    check("badop_strobes", 32'((wr_cnt - b_wr) + (rd_cnt - b_rd)), 0);

    // Out-of-range address
    snap();
    send(8'hAA); send(8'h13);
    wait_cyc(3);
    check("badaddr_err", 32'(err_cnt - b_err), 1);
    check("badaddr_no_wr", 32'(wr_cnt - b_wr), 0);

    // Read timeout
    snap();
    mute = 1'b1;
    send(8'hBB); send(8'h05);
    wait_cyc(10);
    check("to_rd", 32'(rd_cnt - b_rd), 1);
    check("to_err", 32'(err_cnt - b_err), 1);
    check("to_latency", 32'(err_cyc - rd_cyc), 4);
    check("to_no_tx", 32'(acc_cnt - b_acc), 0);
    mute = 1'b0;

    // Reset in the middle of a write
    snap();
    send(8'hAA); send(8'h02);
    @(negedge CLK);
    RST = 1'b0;
    wait_cyc(2);
    RST = 1'b1;
    wait_cyc(1);
    send(8'h11);
    wait_cyc(3);
    check("rstmid_no_wr", 32'(wr_cnt - b_wr), 0);
    check("rstmid_err", 32'(err_cnt - b_err), 1);

    check("no_wr_rd_overlap", 32'(both_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
